// File: rtl/issue_rat_freelist_ctrl_pkg.sv
// Shared definitions for the issue-stage RAT free-list controller:
// PRF index width and controller FSM state encoding.
package issue_rat_freelist_ctrl_pkg;

   localparam int unsigned PRF_W = 6;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WALK = 1'b1
   } state_t;

endpackage

// File: rtl/issue_rat_freelist_prefetch_buf.sv
// Two-entry FIFO holding PRFs fetched ahead from the free list so that an
// allocation can be granted the cycle after the acquire handshake.
module issue_rat_freelist_prefetch_buf
   import issue_rat_freelist_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [PRF_W-1:0] i_push_prf,
   input  logic             i_pop,
   output logic             o_push_ready,
   output logic             o_nonempty,
   output logic [PRF_W-1:0] o_head_prf
);

   logic [PRF_W-1:0] r_mem [2];
   logic             r_rd;
   logic             r_wr;
   logic [1:0]       r_cnt;
   logic             w_push;
   logic             w_pop;

   assign o_push_ready = (r_cnt != 2'd2);
   assign o_nonempty   = (r_cnt != 2'd0);
   assign o_head_prf   = r_mem[r_rd];
   assign w_push       = i_push & o_push_ready;
   assign w_pop        = i_pop & o_nonempty;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_push_prf;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd  <= 1'b0;
         r_wr  <= 1'b0;
         r_cnt <= 2'd0;
      end else begin
         if (w_push) r_wr <= ~r_wr;
         if (w_pop)  r_rd <= ~r_rd;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/issue_rat_freelist_ctrl.sv
// Rename free-list controller: prefetches PRFs, logs every allocation, and on
// a flush walks the un-retired log entries back to the free list.
module issue_rat_freelist_ctrl
   import issue_rat_freelist_ctrl_pkg::*;
#(
   parameter int unsigned LOG_DEPTH_LOG2 = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_alloc_valid,
   output logic             o_alloc_ready,
   output logic [PRF_W-1:0] o_alloc_prf,
   input  logic             i_retire_valid,
   input  logic [PRF_W-1:0] i_commit_prf,
   input  logic             i_commit_valid,
   output logic             o_commit_ready,
   input  logic             i_flush,
   output logic             o_busy,
   output logic             o_fl_acquire_ready,
   input  logic [PRF_W-1:0] i_fl_acquire_prf,
   input  logic             i_fl_acquire_valid,
   output logic [PRF_W-1:0] o_fl_redeemed_prf,
   output logic             o_fl_redeemed_valid,
   input  logic             i_fl_redeemed_ready,
   output logic [PRF_W-1:0] o_fl_abandoned_prf,
   output logic             o_fl_abandoned_valid,
   input  logic             i_fl_abandoned_ready
);

   localparam int unsigned PTR_W = LOG_DEPTH_LOG2 + 1;
   localparam int unsigned DEPTH = 1 << LOG_DEPTH_LOG2;

   state_t           r_state, w_state_nxt;
   logic [PTR_W-1:0] r_head, r_tail, r_walk;
   logic [PTR_W-1:0] w_head_nxt, w_tail_nxt, w_walk_nxt;
   logic [PTR_W-1:0] w_head_post, w_tail_m1;
   logic [PRF_W-1:0] r_log [DEPTH];
   logic             w_buf_nonempty;
   logic [PRF_W-1:0] w_buf_head;
   logic             w_full, w_empty, w_idle;
   logic             w_alloc_fire, w_retire;

   issue_rat_freelist_prefetch_buf u_prefetch_buf (
      .clk          (clk),
      .reset        (reset),
      .i_push       (i_fl_acquire_valid),
      .i_push_prf   (i_fl_acquire_prf),
      .i_pop        (w_alloc_fire),
      .o_push_ready (o_fl_acquire_ready),
      .o_nonempty   (w_buf_nonempty),
      .o_head_prf   (w_buf_head)
   );

   assign w_idle  = (r_state == ST_IDLE);
   assign w_empty = (r_head == r_tail);
   assign w_full  = (r_head[LOG_DEPTH_LOG2-1:0] == r_tail[LOG_DEPTH_LOG2-1:0]) &&
                    (r_head[LOG_DEPTH_LOG2] != r_tail[LOG_DEPTH_LOG2]);

   assign o_alloc_ready = w_idle & w_buf_nonempty & ~w_full & ~i_flush;
   assign o_alloc_prf   = w_buf_head;
   assign w_alloc_fire  = i_alloc_valid & o_alloc_ready;
   assign w_retire      = w_idle & i_retire_valid & ~w_empty;
   assign w_head_post   = r_head + PTR_W'(w_retire);
   assign w_tail_m1     = r_tail - PTR_W'(1);

   assign o_busy               = ~w_idle;
   assign o_fl_abandoned_valid = ~w_idle;
   assign o_fl_abandoned_prf   = r_log[r_walk[LOG_DEPTH_LOG2-1:0]];

   // Commit releases bypass the FSM entirely so they flow even mid-walk.
   assign o_fl_redeemed_prf   = i_commit_prf;
   assign o_fl_redeemed_valid = i_commit_valid;
   assign o_commit_ready      = i_fl_redeemed_ready;

   always_ff @(posedge clk) begin
      if (w_alloc_fire) r_log[r_tail[LOG_DEPTH_LOG2-1:0]] <= w_buf_head;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_head  <= '0;
         r_tail  <= '0;
         r_walk  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_head  <= w_head_nxt;
         r_tail  <= w_tail_nxt;
         r_walk  <= w_walk_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_head_nxt  = r_head;
      w_tail_nxt  = r_tail;
      w_walk_nxt  = r_walk;
      case (r_state)
         ST_IDLE: begin
            // Same-cycle retire is folded in before deciding whether to walk.
            w_head_nxt = w_head_post;
            if (w_alloc_fire) w_tail_nxt = r_tail + PTR_W'(1);
            if (i_flush && (w_head_post != r_tail)) begin
               w_walk_nxt  = w_head_post;
               w_state_nxt = ST_WALK;
            end
         end
         ST_WALK: begin
            if (i_fl_abandoned_ready) begin
               w_walk_nxt = r_walk + PTR_W'(1);
               if (r_walk == w_tail_m1) begin
                  w_head_nxt  = r_tail;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_issue_rat_freelist_ctrl.sv
// Self-checking bench for issue_rat_freelist_ctrl: scoreboard queues hold the
// expected allocation order, log contents and abandon order.
module tb_issue_rat_freelist_ctrl;

   logic       clk;
   logic       reset;
   logic       i_alloc_valid;
   logic       o_alloc_ready;
   logic [5:0] o_alloc_prf;
   logic       i_retire_valid;
   logic [5:0] i_commit_prf;
   logic       i_commit_valid;
   logic       o_commit_ready;
   logic       i_flush;
   logic       o_busy;
   logic       o_fl_acquire_ready;
   logic [5:0] i_fl_acquire_prf;
   logic       i_fl_acquire_valid;
   logic [5:0] o_fl_redeemed_prf;
   logic       o_fl_redeemed_valid;
   logic       i_fl_redeemed_ready;
   logic [5:0] o_fl_abandoned_prf;
   logic       o_fl_abandoned_valid;
   logic       i_fl_abandoned_ready;

   int total = 0;
   int bad   = 0;
   int alloc_q[$];
   int log_q[$];
   int aband_q[$];

   issue_rat_freelist_ctrl #(.LOG_DEPTH_LOG2(5)) dut (
      .clk                  (clk),
      .reset                (reset),
      .i_alloc_valid        (i_alloc_valid),
      .o_alloc_ready        (o_alloc_ready),
      .o_alloc_prf          (o_alloc_prf),
      .i_retire_valid       (i_retire_valid),
      .i_commit_prf         (i_commit_prf),
      .i_commit_valid       (i_commit_valid),
      .o_commit_ready       (o_commit_ready),
      .i_flush              (i_flush),
      .o_busy               (o_busy),
      .o_fl_acquire_ready   (o_fl_acquire_ready),
      .i_fl_acquire_prf     (i_fl_acquire_prf),
      .i_fl_acquire_valid   (i_fl_acquire_valid),
      .o_fl_redeemed_prf    (o_fl_redeemed_prf),
      .o_fl_redeemed_valid  (o_fl_redeemed_valid),
      .i_fl_redeemed_ready  (i_fl_redeemed_ready),
      .o_fl_abandoned_prf   (o_fl_abandoned_prf),
      .o_fl_abandoned_valid (o_fl_abandoned_valid),
      .i_fl_abandoned_ready (i_fl_abandoned_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      i_alloc_valid        = 1'b0;
      i_retire_valid       = 1'b0;
      i_commit_prf         = '0;
      i_commit_valid       = 1'b0;
      i_flush              = 1'b0;
      i_fl_acquire_prf     = '0;
      i_fl_acquire_valid   = 1'b0;
      i_fl_redeemed_ready  = 1'b1;
      i_fl_abandoned_ready = 1'b1;
   endtask

   task automatic do_reset();
      idle_in();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      alloc_q.delete();
      log_q.delete();
      aband_q.delete();
   endtask

   // Offers n_offer PRFs (base + stride*k) and requests n_alloc allocations.
   task automatic stream(input int n_alloc, input int n_offer, input int base, input int stride);
      int offered   = 0;
      int allocated = 0;
      int n         = 0;
      while (n < 200 && !(allocated == n_alloc && offered == n_offer)) begin
         i_fl_acquire_valid = (offered < n_offer);
         i_fl_acquire_prf   = 6'(base + stride * offered);
         i_alloc_valid      = (allocated < n_alloc);
         #1;
         if (i_alloc_valid && o_alloc_ready) begin
            total++;
            if (alloc_q.size() == 0) begin
               bad++;
               $display("FAIL stream_alloc_unexpected: got prf %0d want no grant", o_alloc_prf);
            end else begin
               if (o_alloc_prf !== 6'(alloc_q[0])) begin
                  bad++;
                  $display("FAIL stream_alloc_prf: got %0d want %0d", o_alloc_prf, alloc_q[0]);
               end
               log_q.push_back(alloc_q.pop_front());
            end
            allocated++;
         end
         if (i_fl_acquire_valid && o_fl_acquire_ready) begin
            alloc_q.push_back(base + stride * offered);
            offered++;
         end
         cyc();
         n++;
      end
      total++;
      if (!(allocated == n_alloc && offered == n_offer)) begin
         bad++;
         $display("FAIL stream_timeout: got allocs %0d want %0d", allocated, n_alloc);
      end
      idle_in();
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total++; if (o_alloc_ready !== 1'b0) begin bad++; $display("FAIL reset_alloc_ready: got %b want 0", o_alloc_ready); end
      total++; if (o_fl_abandoned_valid !== 1'b0) begin bad++; $display("FAIL reset_aband_valid: got %b want 0", o_fl_abandoned_valid); end
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      total++; if (o_fl_acquire_ready !== 1'b1) begin bad++; $display("FAIL reset_acq_ready: got %b want 1", o_fl_acquire_ready); end
      i_commit_valid      = 1'b1;
      i_commit_prf        = 6'd12;
      i_fl_redeemed_ready = 1'b0;
      #1;
      total++; if (o_fl_redeemed_valid !== 1'b1 || o_fl_redeemed_prf !== 6'd12) begin bad++; $display("FAIL idle_commit_pass: got %b/%0d want 1/12", o_fl_redeemed_valid, o_fl_redeemed_prf); end
      total++; if (o_commit_ready !== 1'b0) begin bad++; $display("FAIL idle_commit_ready: got %b want 0", o_commit_ready); end
      idle_in();
   endtask

   task automatic test_prefetch();
      do_reset();
      i_fl_acquire_valid = 1'b1;
      i_fl_acquire_prf   = 6'd0;
      #1;
      total++; if (o_alloc_ready !== 1'b0) begin bad++; $display("FAIL pf_empty_ready: got %b want 0", o_alloc_ready); end
      alloc_q.push_back(0);
      cyc();
      i_fl_acquire_prf = 6'd1;
      #1;
      total++; if (o_alloc_ready !== 1'b1 || o_alloc_prf !== 6'(alloc_q[0])) begin bad++; $display("FAIL pf_first_ready: got %b/%0d want 1/%0d", o_alloc_ready, o_alloc_prf, alloc_q[0]); end
      total++; if (o_fl_acquire_ready !== 1'b1) begin bad++; $display("FAIL pf_acq_ready_cnt1: got %b want 1", o_fl_acquire_ready); end
      alloc_q.push_back(1);
      cyc();
      i_fl_acquire_valid = 1'b0;
      i_alloc_valid      = 1'b1;
      #1;
      total++; if (o_fl_acquire_ready !== 1'b0) begin bad++; $display("FAIL pf_acq_ready_cnt2: got %b want 0", o_fl_acquire_ready); end
      total++; if (o_alloc_prf !== 6'(alloc_q[0])) begin bad++; $display("FAIL pf_alloc0: got %0d want %0d", o_alloc_prf, alloc_q[0]); end
      void'(alloc_q.pop_front());
      cyc();
      // push and pop together: count holds, order kept
      i_fl_acquire_valid = 1'b1;
      i_fl_acquire_prf   = 6'd2;
      #1;
      total++; if (o_alloc_ready !== 1'b1 || o_alloc_prf !== 6'(alloc_q[0])) begin bad++; $display("FAIL pf_alloc1: got %b/%0d want 1/%0d", o_alloc_ready, o_alloc_prf, alloc_q[0]); end
      void'(alloc_q.pop_front());
      alloc_q.push_back(2);
      cyc();
      i_fl_acquire_valid = 1'b0;
      #1;
      total++; if (o_alloc_prf !== 6'(alloc_q[0]) || o_fl_acquire_ready !== 1'b1) begin bad++; $display("FAIL pf_pushpop: got %0d/%b want %0d/1", o_alloc_prf, o_fl_acquire_ready, alloc_q[0]); end
      void'(alloc_q.pop_front());
      cyc();
      i_alloc_valid = 1'b0;
      #1;
      total++; if (o_alloc_ready !== 1'b0) begin bad++; $display("FAIL pf_drained: got %b want 0", o_alloc_ready); end
      idle_in();
   endtask

   task automatic test_full();
      do_reset();
      stream(32, 34, 0, 1);
      i_alloc_valid = 1'b1;
      for (int unsigned k = 0; k < 3; k++) begin
         #1;
         total++; if (o_alloc_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", o_alloc_ready); end
         cyc();
      end
      i_alloc_valid  = 1'b0;
      i_retire_valid = 1'b1;
      #1;
      total++; if (o_alloc_ready !== 1'b0) begin bad++; $display("FAIL full_retire_cycle: got %b want 0", o_alloc_ready); end
      cyc();
      void'(log_q.pop_front());
      i_retire_valid = 1'b0;
      i_alloc_valid  = 1'b1;
      #1;
      total++; if (o_alloc_ready !== 1'b1 || o_alloc_prf !== 6'(alloc_q[0])) begin bad++; $display("FAIL full_after_retire: got %b/%0d want 1/%0d", o_alloc_ready, o_alloc_prf, alloc_q[0]); end
      log_q.push_back(alloc_q.pop_front());
      cyc();
      i_alloc_valid = 1'b0;
      #1;
      total++; if (o_alloc_ready !== 1'b0) begin bad++; $display("FAIL full_again: got %b want 0", o_alloc_ready); end
      idle_in();
   endtask

   task automatic test_flush();
      int busy_n = 0;
      do_reset();
      stream(3, 3, 4, 2);
      i_retire_valid = 1'b1;
      cyc();
      void'(log_q.pop_front());
      i_retire_valid = 1'b0;
      i_flush        = 1'b1;
      aband_q        = log_q;
      log_q.delete();
      #1;
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL flush_cycle_busy: got %b want 0", o_busy); end
      cyc();
      i_flush = 1'b0;
      for (int unsigned k = 0; k < 6; k++) begin
         #1;
         if (o_busy === 1'b1) busy_n++;
         total++; if (o_fl_abandoned_valid !== o_busy) begin bad++; $display("FAIL flush_valid_vs_busy: got %b want %b", o_fl_abandoned_valid, o_busy); end
         if (o_fl_abandoned_valid === 1'b1) begin
            total++;
            if (aband_q.size() == 0) begin
               bad++; $display("FAIL flush_extra_abandon: got %0d want none", o_fl_abandoned_prf);
            end else begin
               if (o_fl_abandoned_prf !== 6'(aband_q[0])) begin bad++; $display("FAIL flush_abandon_prf: got %0d want %0d", o_fl_abandoned_prf, aband_q[0]); end
               void'(aband_q.pop_front());
            end
         end
         cyc();
      end
      total++; if (busy_n != 2) begin bad++; $display("FAIL flush_busy_cycles: got %0d want 2", busy_n); end
      total++; if (aband_q.size() != 0) begin bad++; $display("FAIL flush_missing_abandon: got %0d left want 0", aband_q.size()); end
      i_flush = 1'b1;
      cyc();
      i_flush = 1'b0;
      #1;
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL flush_log_empty: got busy %b want 0", o_busy); end
      idle_in();
   endtask

   task automatic test_flush_retire();
      do_reset();
      stream(1, 1, 5, 1);
      i_retire_valid = 1'b1;
      i_flush        = 1'b1;
      cyc();
      idle_in();
      for (int unsigned k = 0; k < 2; k++) begin
         #1;
         total++; if (o_busy !== 1'b0 || o_fl_abandoned_valid !== 1'b0) begin bad++; $display("FAIL flush_retire_idle: got %b/%b want 0/0", o_busy, o_fl_abandoned_valid); end
         cyc();
      end
   endtask

   task automatic test_walk_stall();
      int n = 0;
      do_reset();
      stream(3, 4, 20, 1);
      i_flush = 1'b1;
      aband_q = log_q;
      log_q.delete();
      cyc();
      i_retire_valid = 1'b1;
      i_commit_valid = 1'b1;
      i_commit_prf   = 6'd12;
      while (n < 20 && aband_q.size() > 0) begin
         i_fl_abandoned_ready = (n % 3 != 0);
         i_fl_redeemed_ready  = n[0];
         #1;
         total++; if (o_busy !== 1'b1 || o_fl_abandoned_valid !== 1'b1) begin bad++; $display("FAIL walk_busy: got %b/%b want 1/1", o_busy, o_fl_abandoned_valid); end
         total++; if (o_alloc_ready !== 1'b0) begin bad++; $display("FAIL walk_alloc_ready: got %b want 0", o_alloc_ready); end
         total++; if (o_fl_redeemed_valid !== 1'b1 || o_fl_redeemed_prf !== 6'd12 || o_commit_ready !== n[0]) begin bad++; $display("FAIL walk_commit: got %b/%0d/%b want 1/12/%b", o_fl_redeemed_valid, o_fl_redeemed_prf, o_commit_ready, n[0]); end
         total++; if (o_fl_abandoned_prf !== 6'(aband_q[0])) begin bad++; $display("FAIL walk_abandon_prf: got %0d want %0d", o_fl_abandoned_prf, aband_q[0]); end
         if (i_fl_abandoned_ready) void'(aband_q.pop_front());
         cyc();
         n++;
      end
      idle_in();
      #1;
      total++; if (aband_q.size() != 0 || n != 5) begin bad++; $display("FAIL walk_length: got %0d cycles want 5", n); end
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL walk_end_busy: got %b want 0", o_busy); end
      total++; if (o_alloc_ready !== 1'b1 || o_alloc_prf !== 6'(alloc_q[0])) begin bad++; $display("FAIL walk_buffer_kept: got %b/%0d want 1/%0d", o_alloc_ready, o_alloc_prf, alloc_q[0]); end
      cyc();
   endtask

   task automatic test_reset_walk();
      do_reset();
      stream(2, 2, 30, 1);
      i_flush = 1'b1;
      cyc();
      i_flush              = 1'b0;
      i_fl_abandoned_ready = 1'b0;
      #1;
      total++; if (o_busy !== 1'b1 || o_fl_abandoned_prf !== 6'd30) begin bad++; $display("FAIL rw_walking: got %b/%0d want 1/30", o_busy, o_fl_abandoned_prf); end
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      idle_in();
      #1;
      total++; if (o_fl_abandoned_valid !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL rw_abort: got %b/%b want 0/0", o_fl_abandoned_valid, o_busy); end
      i_flush = 1'b1;
      cyc();
      i_flush = 1'b0;
      #1;
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rw_log_empty: got busy %b want 0", o_busy); end
      cyc();
   endtask

   initial begin
      reset = 1'b1;
      idle_in();
      test_reset();
      test_prefetch();
      test_full();
      test_flush();
      test_flush_retire();
      test_walk_stall();
      test_reset_walk();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
